// File: rtl/tiled_rom_multiplier.sv
// Multi-cycle unsigned multiplier: one digit-pair product per clock from a constant
// lookup table, shifted and accumulated into a 2W-bit result, with valid/ready on both sides.
module tiled_rom_multiplier #(
    parameter int unsigned DIGIT_W    = 5,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned ZERO_SKIP  = 1,
    localparam int unsigned W         = DIGIT_W * NUM_DIGITS
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    localparam int unsigned PW        = 2 * W;
    localparam int unsigned DPW       = 2 * DIGIT_W;
    localparam int unsigned ROM_DEPTH = 1 << DPW;
    localparam int unsigned CW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] LAST    = CW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [W-1:0]    x_q;
    logic [W-1:0]    y_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   product_q;
    logic [CW-1:0]   i_q;
    logic [CW-1:0]   j_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    // Constant digit-product table, address {y digit, x digit}
    logic [DPW-1:0] rom [ROM_DEPTH];
    for (genvar a = 0; a < ROM_DEPTH; a++) begin : g_rom
        assign rom[a] = DPW'((a >> DIGIT_W) * (a % (1 << DIGIT_W)));
    end

    logic [DIGIT_W-1:0] xd_c;
    logic [DIGIT_W-1:0] yd_c;
    logic [DPW-1:0]     dprod_c;
    logic [PW-1:0]      term_c;
    logic [PW-1:0]      sum_c;
    logic               skip_c;

    assign xd_c    = DIGIT_W'(x_q >> (32'(i_q) * DIGIT_W));
    assign yd_c    = DIGIT_W'(y_q >> (32'(j_q) * DIGIT_W));
    assign dprod_c = rom[{yd_c, xd_c}];
    assign term_c  = PW'(dprod_c) << ((32'(i_q) + 32'(j_q)) * DIGIT_W);
    assign sum_c   = acc_q + term_c;
    assign skip_c  = (ZERO_SKIP != 0) && ((x == '0) || (y == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            i_q         <= '0;
            j_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        x_q        <= x;
                        y_q        <= y;
                        acc_q      <= '0;
                        i_q        <= '0;
                        j_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (skip_c) begin
                            product_q   <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    // j runs fastest; the last pair commits the product directly
                    acc_q <= sum_c;
                    if (j_q == LAST) begin
                        j_q <= '0;
                        if (i_q == LAST) begin
                            product_q   <= sum_c;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            i_q <= i_q + 1'b1;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tiled_rom_multiplier.sv
// Bench for tiled_rom_multiplier: directed vector table, handshake corner cases,
// and random operands checked against plain integer multiplication.
module tb_tiled_rom_multiplier;

    localparam int unsigned DW  = 5;
    localparam int unsigned ND  = 4;
    localparam int unsigned W   = DW * ND;
    localparam int unsigned PW  = 2 * W;
    localparam int          LAT = ND * ND;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
    logic          busy;

    logic          z_in_valid;
    logic          z_in_ready;
    logic [W-1:0]  z_x;
    logic [W-1:0]  z_y;
    logic          z_out_valid;
    logic          z_out_ready;
    logic [PW-1:0] z_product;
    logic          z_busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tiled_rom_multiplier #(.DIGIT_W(DW), .NUM_DIGITS(ND), .ZERO_SKIP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    tiled_rom_multiplier #(.DIGIT_W(DW), .NUM_DIGITS(ND), .ZERO_SKIP(0)) dut_noskip (
        .clk(clk), .rst_n(rst_n), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .x(z_x), .y(z_y), .out_valid(z_out_valid), .out_ready(z_out_ready),
        .product(z_product), .busy(z_busy)
    );

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] exp;
        int            lat;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept one operand pair, measure latency, optionally stall, then release.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [PW-1:0] exp, input int lat, input int hold,
                         input string name);
        int n;
        bit locked;
        bit stable;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_in_ready"}, 64'(in_ready), 64'(1));
        x = a;
        y = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        locked = 1'b1;
        while (!out_valid && n < 100) begin
            if (in_ready || !busy) locked = 1'b0;
            @(negedge clk);
            n++;
        end
        if (in_ready || !busy) locked = 1'b0;
        chk({name, "_latency"}, 64'(n), 64'(lat));
        chk({name, "_product"}, 64'(product), 64'(exp));
        chk({name, "_locked"}, 64'(locked), 64'(1));
        if (hold > 0) begin
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                x = 20'd7;
                y = 20'd9;
                in_valid = 1'b1;
                @(negedge clk);
                if (!out_valid || product !== exp || in_ready) stable = 1'b0;
            end
            in_valid = 1'b0;
            chk({name, "_hold_stable"}, 64'(stable), 64'(1));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_release"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [W-1:0]  ba [3];
        logic [W-1:0]  bb [3];
        logic [PW-1:0] be [3];
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        longint unsigned model;

        vecs[0] = '{a: 20'd3,       b: 20'd3,       exp: 40'd9,            lat: LAT};
        vecs[1] = '{a: 20'h21,      b: 20'h21,      exp: 40'h441,          lat: LAT};
        vecs[2] = '{a: 20'hFFFFF,   b: 20'hFFFFF,   exp: 40'hFFFFE00001,   lat: LAT};
        vecs[3] = '{a: 20'd12345,   b: 20'd678,     exp: 40'd8369910,      lat: LAT};
        vecs[4] = '{a: 20'd0,       b: 20'hABCDE,   exp: 40'd0,            lat: 0};
        vecs[5] = '{a: 20'hABCDE,   b: 20'd0,       exp: 40'd0,            lat: 0};
        vecs[6] = '{a: 20'd1,       b: 20'hFFFFF,   exp: 40'hFFFFF,        lat: LAT};

        in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
        z_in_valid = 1'b0; z_out_ready = 1'b0; z_x = '0; z_y = '0;

        repeat (2) @(negedge clk);
        chk("reset_state", {60'd0, in_ready, out_valid, busy, 1'b0}, 64'b1000);
        chk("reset_product", 64'(product), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++)
            do_op(vecs[k].a, vecs[k].b, vecs[k].exp, vecs[k].lat, 0, $sformatf("vec%0d", k));

        do_op(20'd12345, 20'd678, 40'd8369910, LAT, 5, "backpressure");
        do_op(20'd7, 20'd9, 40'd63, LAT, 0, "after_bp");

        // Asynchronous reset after the seventh CALC edge
        x = 20'd12345; y = 20'd678; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("midop_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("midop_rst_flags", {61'd0, in_ready, out_valid, busy}, 64'b100);
        chk("midop_rst_product", 64'(product), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midop_no_pulse", 64'(out_valid), 64'(0));
        do_op(20'd2, 20'd3, 40'd6, LAT, 0, "post_rst");

        // Back-to-back with both handshakes tied high
        ba[0] = 20'd1;     bb[0] = 20'd1;    be[0] = 40'd1;
        ba[1] = 20'h1F;    bb[1] = 20'h1F;   be[1] = 40'h3C1;
        ba[2] = 20'hFFFFF; bb[2] = 20'd1;    be[2] = 40'hFFFFF;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            x = ba[k];
            y = bb[k];
            @(negedge clk);
            chk($sformatf("b2b%0d_accepted", k), {62'd0, busy, in_ready}, 64'b10);
            n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("b2b%0d_latency", k), 64'(n), 64'(LAT));
            chk($sformatf("b2b%0d_product", k), 64'(product), 64'(be[k]));
            @(negedge clk);
            chk($sformatf("b2b%0d_idle", k), {62'd0, in_ready, out_valid}, 64'b10);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        // Zero operand without the bypass still takes the full digit loop
        z_x = 20'd0; z_y = 20'hABCDE; z_in_valid = 1'b1;
        @(negedge clk);
        z_in_valid = 1'b0;
        n = 0;
        while (!z_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("noskip_latency", 64'(n), 64'(LAT));
        chk("noskip_product", 64'(z_product), 64'(0));
        z_out_ready = 1'b1;
        @(negedge clk);
        z_out_ready = 1'b0;
        chk("noskip_release", 64'(z_in_ready), 64'(1));

        for (int k = 0; k < 25; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 7) == 0) ra = '0;
            if ($urandom_range(0, 7) == 0) rb = '0;
            if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 31));
            model = longint'(ra) * longint'(rb);
            do_op(ra, rb, PW'(model), (ra == 0 || rb == 0) ? 0 : LAT, 0,
                  $sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
